// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: round-robin owner of the single SRAM_Controller port for
// VGA fetch (0), UART loader (1), Milestone 1 (2) and Milestone 2 (3).
// Bursts are bounded by MAX_BURST. Every owner change inserts one TURN cycle.
// Read-data-valid strobes are routed back to the requester that issued each read.
// Optional feature: define SRAM_ARB_VGA_PREEMPT_EN to let requester 0 preempt any owner.
module sram_access_arbiter #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned MAX_BURST    = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:0]  req,
  input  logic [3:0]  we_n,
  input  logic [71:0] addr,
  input  logic [63:0] wdata,
  output logic [3:0]  gnt,
  output logic [3:0]  rdata_valid,
  output logic [15:0] rdata,
  output logic [1:0]  owner,
  output logic        busy,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data
);

  localparam int unsigned AW       = 18;
  localparam int unsigned DW       = 16;
  localparam int unsigned CW       = 8;
  localparam int unsigned TAG_W    = 3;
  localparam int unsigned TAG_SR_W = TAG_W * READ_LATENCY;

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;

  state_t              state;
  logic [CW-1:0]       burst_cnt;
  logic [TAG_SR_W-1:0] tag_sr;

  logic       accept;
  logic       others;
  logic       burst_last;
  logic       preempt_hit;
  logic [1:0] rr_winner;
  logic [1:0] turn_winner;
  logic [2:0] new_tag;
  logic [2:0] exit_tag;
  logic [6:0] a_lsb;
  logic [5:0] wd_lsb;

  // First requester with req high, scanning last+1, last+2, ... and last itself
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign accept     = (state == S_OWN) && req[owner];
  assign others     = |(req & ~(4'b0001 << owner));
  assign burst_last = (burst_cnt == CW'(MAX_BURST - 1));
  assign rr_winner  = rr_pick(owner, req);
  assign new_tag    = {accept & we_n[owner], owner};
  assign exit_tag   = tag_sr[TAG_SR_W-1 -: TAG_W];
  assign a_lsb      = 7'(owner) * 7'(AW);
  assign wd_lsb     = 6'(owner) * 6'(DW);

`ifdef SRAM_ARB_VGA_PREEMPT_EN
  assign preempt_hit = (owner != 2'd0) && req[0];
  assign turn_winner = req[0] ? 2'd0 : rr_winner;
`else
  assign preempt_hit = 1'b0;
  assign turn_winner = rr_winner;
`endif

  // Read data is passed through; the strobe is decoded from the tag leaving the pipe
  assign rdata       = SRAM_read_data;
  assign rdata_valid = exit_tag[2] ? (4'b0001 << exit_tag[1:0]) : 4'b0000;

  // SRAM port driven from the owner only on an accepted access
  always_comb begin
    SRAM_address    = '0;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    if (accept) begin
      SRAM_address    = addr[a_lsb +: AW];
      SRAM_write_data = wdata[wd_lsb +: DW];
      SRAM_we_n       = we_n[owner];
    end
  end

  // Grant FSM, burst counter and read tag pipe
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      gnt       <= '0;
      owner     <= '0;
      busy      <= 1'b0;
      burst_cnt <= '0;
      tag_sr    <= '0;
    end else begin
      tag_sr <= (tag_sr << TAG_W) | TAG_SR_W'(new_tag);
      case (state)
        S_IDLE: begin
          if (|req) begin
            state     <= S_OWN;
            gnt       <= 4'b0001 << rr_winner;
            owner     <= rr_winner;
            busy      <= 1'b1;
            burst_cnt <= '0;
          end
        end
        S_OWN: begin
          if (!req[owner] || preempt_hit || (burst_last && others)) begin
            state <= S_TURN;
            gnt   <= '0;
          end else if (burst_last) begin
            burst_cnt <= '0;
          end else begin
            burst_cnt <= burst_cnt + CW'(1);
          end
        end
        S_TURN: begin
          if (|req) begin
            state     <= S_OWN;
            gnt       <= 4'b0001 << turn_winner;
            owner     <= turn_winner;
            burst_cnt <= '0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: inputs change 1 ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_sram_access_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  we_n;
  logic [71:0] addr;
  logic [63:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  rdata_valid;
  logic [15:0] rdata;
  logic [1:0]  owner;
  logic        busy;
  logic [17:0] sram_address;
  logic [15:0] sram_write_data;
  logic        sram_we_n;
  logic [15:0] sram_read_data;

  int n_vec;
  int n_err;

  sram_access_arbiter #(.READ_LATENCY(2), .MAX_BURST(16)) dut (
    .Clock(clk),
    .Reset(rst),
    .req(req),
    .we_n(we_n),
    .addr(addr),
    .wdata(wdata),
    .gnt(gnt),
    .rdata_valid(rdata_valid),
    .rdata(rdata),
    .owner(owner),
    .busy(busy),
    .SRAM_address(sram_address),
    .SRAM_write_data(sram_write_data),
    .SRAM_we_n(sram_we_n),
    .SRAM_read_data(sram_read_data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // SRAM model: word is a fixed function of the address, returned two cycles later
  function automatic logic [15:0] sram_f(input logic [17:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  logic [15:0] d1, d2;
  always @(posedge clk) begin
    d1 <= sram_f(sram_address);
    d2 <= d1;
  end
  assign sram_read_data = d2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; we_n = '1; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset gnt: got %b want 0000", gnt); end
    n_vec++; if (rdata_valid !== 4'b0000) begin n_err++; $display("FAIL reset rdata_valid: got %b want 0000", rdata_valid); end
    n_vec++; if (owner !== 2'd0) begin n_err++; $display("FAIL reset owner: got %0d want 0", owner); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
    n_vec++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL reset we_n: got %b want 1", sram_we_n); end
    n_vec++; if (sram_address !== 18'h0) begin n_err++; $display("FAIL reset address: got %h want 0", sram_address); end
    n_vec++; if (sram_write_data !== 16'h0) begin n_err++; $display("FAIL reset wdata: got %h want 0", sram_write_data); end
    tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single_read();
    tick();
    req = 4'b0100; we_n = 4'b1111; addr[36 +: 18] = 18'h00010;
    @(negedge clk);
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL single idle gnt: got %b want 0000", gnt); end
    tick();
    @(negedge clk);
    n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL single gnt: got %b want 0100", gnt); end
    n_vec++; if (sram_address !== 18'h00010) begin n_err++; $display("FAIL single address: got %h want 00010", sram_address); end
    n_vec++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL single we_n: got %b want 1", sram_we_n); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single busy: got %b want 1", busy); end
    n_vec++; if (owner !== 2'd2) begin n_err++; $display("FAIL single owner: got %0d want 2", owner); end
    tick();
    req = 4'b0000;
    @(negedge clk);
    n_vec++; if (rdata_valid !== 4'b0000) begin n_err++; $display("FAIL single early valid: got %b want 0000", rdata_valid); end
    tick();
    @(negedge clk);
    n_vec++; if (rdata_valid !== 4'b0100) begin n_err++; $display("FAIL single valid: got %b want 0100", rdata_valid); end
    n_vec++; if (rdata !== sram_f(18'h00010)) begin n_err++; $display("FAIL single rdata: got %h want %h", rdata, sram_f(18'h00010)); end
    tick();
    @(negedge clk);
    n_vec++; if (rdata_valid !== 4'b0000) begin n_err++; $display("FAIL single late valid: got %b want 0000", rdata_valid); end
    repeat (2) tick();
  endtask

  task automatic test_burst_limit();
    logic [3:0] exp_g;
    tick();
    req = 4'b0110; we_n = 4'b1111;
    addr[18 +: 18] = 18'h11111; addr[36 +: 18] = 18'h22222;
    for (int c = 1; c <= 35; c++) begin
      tick();
      @(negedge clk);
      if (c <= 16)      exp_g = 4'b0010;
      else if (c == 17) exp_g = 4'b0000;
      else if (c <= 33) exp_g = 4'b0100;
      else if (c == 34) exp_g = 4'b0000;
      else              exp_g = 4'b0010;
      n_vec++; if (gnt !== exp_g) begin n_err++; $display("FAIL burst gnt c%0d: got %b want %b", c, gnt, exp_g); end
      if (c == 17) begin
        n_vec++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL burst turn we_n: got %b want 1", sram_we_n); end
        n_vec++; if (sram_address !== 18'h0) begin n_err++; $display("FAIL burst turn address: got %h want 0", sram_address); end
        n_vec++; if (owner !== 2'd1) begin n_err++; $display("FAIL burst turn owner: got %0d want 1", owner); end
      end
      if (c == 18) begin
        n_vec++; if (sram_address !== 18'h22222) begin n_err++; $display("FAIL burst address r2: got %h want 22222", sram_address); end
      end
    end
    tick();
    req = 4'b0000;
    repeat (5) tick();
  endtask

  task automatic test_preempt();
    logic [3:0] exp_g;
    tick();
    req = 4'b0100; we_n = 4'b1111; addr[36 +: 18] = 18'h00200; addr[0 +: 18] = 18'h00000;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c == 4) req[0] = 1'b1;
      @(negedge clk);
`ifdef SRAM_ARB_VGA_PREEMPT_EN
      if (c <= 4)      exp_g = 4'b0100;
      else if (c == 5) exp_g = 4'b0000;
      else             exp_g = 4'b0001;
`else
      if (c <= 16)      exp_g = 4'b0100;
      else if (c == 17) exp_g = 4'b0000;
      else              exp_g = 4'b0001;
`endif
      n_vec++; if (gnt !== exp_g) begin n_err++; $display("FAIL preempt gnt c%0d: got %b want %b", c, gnt, exp_g); end
    end
    tick();
    req = 4'b0000;
    repeat (5) tick();
  endtask

  task automatic test_write();
    tick();
    req = 4'b1000; we_n = 4'b0111; addr[54 +: 18] = 18'h3FFFF; wdata[48 +: 16] = 16'hBEEF;
    tick();
    @(negedge clk);
    n_vec++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL write gnt: got %b want 1000", gnt); end
    n_vec++; if (sram_we_n !== 1'b0) begin n_err++; $display("FAIL write we_n: got %b want 0", sram_we_n); end
    n_vec++; if (sram_address !== 18'h3FFFF) begin n_err++; $display("FAIL write address: got %h want 3ffff", sram_address); end
    n_vec++; if (sram_write_data !== 16'hBEEF) begin n_err++; $display("FAIL write data: got %h want beef", sram_write_data); end
    tick();
    req = 4'b0000; we_n = 4'b1111;
    @(negedge clk);
    n_vec++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL write idle we_n: got %b want 1", sram_we_n); end
    for (int c = 0; c < 4; c++) begin
      n_vec++; if (rdata_valid !== 4'b0000) begin n_err++; $display("FAIL write valid c%0d: got %b want 0000", c, rdata_valid); end
      tick();
      @(negedge clk);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_read();
    tick();
    req = 4'b0010; we_n = 4'b1111; addr[18 +: 18] = 18'h00100;
    tick();
    @(negedge clk);
    n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL b2b gnt: got %b want 0010", gnt); end
    n_vec++; if (sram_address !== 18'h00100) begin n_err++; $display("FAIL b2b address0: got %h want 00100", sram_address); end
    tick();
    addr[18 +: 18] = 18'h00101;
    @(negedge clk);
    n_vec++; if (sram_address !== 18'h00101) begin n_err++; $display("FAIL b2b address1: got %h want 00101", sram_address); end
    tick();
    addr[18 +: 18] = 18'h00102;
    @(negedge clk);
    n_vec++; if (rdata_valid !== 4'b0010) begin n_err++; $display("FAIL b2b valid: got %b want 0010", rdata_valid); end
    n_vec++; if (rdata !== sram_f(18'h00100)) begin n_err++; $display("FAIL b2b rdata: got %h want %h", rdata, sram_f(18'h00100)); end
    tick();
    rst = 1'b1; req = 4'b0000;
    #1;
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rst gnt: got %b want 0000", gnt); end
    n_vec++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL rst we_n: got %b want 1", sram_we_n); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst busy: got %b want 0", busy); end
    n_vec++; if (rdata_valid !== 4'b0000) begin n_err++; $display("FAIL rst valid: got %b want 0000", rdata_valid); end
    tick();
    @(negedge clk);
    n_vec++; if (rdata_valid !== 4'b0000) begin n_err++; $display("FAIL rst valid2: got %b want 0000", rdata_valid); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (rdata_valid !== 4'b0000) begin n_err++; $display("FAIL rst valid3: got %b want 0000", rdata_valid); end
    tick();
    req = 4'b1111; we_n = 4'b1111;
    @(negedge clk);
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL post-rst idle gnt: got %b want 0000", gnt); end
    tick();
    @(negedge clk);
    n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL post-rst gnt: got %b want 0010", gnt); end
    n_vec++; if (owner !== 2'd1) begin n_err++; $display("FAIL post-rst owner: got %0d want 1", owner); end
    tick();
    req = 4'b0000;
    repeat (5) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single_read();
    test_burst_limit();
    test_preempt();
    test_write();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_access_arbiter.md
# sram_access_arbiter

Shares the single SRAM_Controller port between four requesters: VGA fetch (0), UART loader (1), Milestone 1 (2) and Milestone 2 (3). It replaces top-state address/we_n muxing with a registered-grant round-robin arbiter that bounds bursts, inserts a one-cycle turnaround on every owner change, and routes read-data-valid strobes back to the requester that issued each read.

## Interface
- READ_LATENCY, 2: cycles from SRAM_address driven to SRAM_read_data valid.
- MAX_BURST, 16: maximum accepted accesses per grant while another requester waits; range 1..255.
- Clock  in  1  50 MHz system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req  in  4  per-requester access request; hold high with stable addr/we_n/wdata until accepted.
- we_n  in  4  per-requester write enable, active low.
- addr  in  72  packed 18-bit addresses; requester i uses addr[18*i+17:18*i].
- wdata  in  64  packed 16-bit write data; requester i uses wdata[16*i+15:16*i].
- gnt  out  4  registered one-hot grant.
- rdata_valid  out  4  one-cycle strobe; SRAM_read_data belongs to requester i.
- rdata  out  16  SRAM_read_data passed through combinationally.
- owner  out  2  index of current or last owner.
- busy  out  1  high in OWN and TURN.
- SRAM_address  out  18  to SRAM_Controller.
- SRAM_write_data  out  16  to SRAM_Controller.
- SRAM_we_n  out  1  to SRAM_Controller.
- SRAM_read_data  in  16  from SRAM_Controller.

## Operation
- States: IDLE, OWN, TURN.
- IDLE: no gnt. If any req, select a winner and go to OWN; gnt[winner] is high next cycle.
- Selection: round-robin. Scan indices owner+1, owner+2, ... mod 4 and take the first with req high.
- OWN: each cycle with gnt[i] and req[i] high is one accepted access. SRAM_address, SRAM_we_n and SRAM_write_data are driven combinationally from requester i that same cycle.
- OWN with gnt[i] high and req[i] low: no access, SRAM_we_n=1.
- Burst counter (8 bits): cleared on entry to OWN, incremented per accepted access.
- Release the owner at the clock edge when either condition holds:
  - req[i] is low;
  - the counter has reached MAX_BURST-1 on an accepted access and another req is high. If no other req is high, the counter clears and the owner keeps the grant.
- Release leads to TURN: gnt=0, SRAM_we_n=1, SRAM_address=0, owner unchanged.
- TURN ends after one cycle: go to OWN with the next round-robin winner (the previous owner may win again only if no other req is high), or go to IDLE if no req.
- Read tagging: each accepted access with we_n[i]=1 pushes {1, i} into a READ_LATENCY-deep shift register. When the tag exits, rdata_valid[i] pulses for one cycle. Writes push {0, x}.
- Width rules: addr and wdata slices are passed unmodified; there is no address arithmetic.

## Timing
- Reset values: gnt=0, rdata_valid=0, owner=0, busy=0, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, state IDLE, burst counter 0, tag pipe cleared.
- Request-to-grant latency: 1 cycle from IDLE; 2 cycles when a turnaround is required.
- Read latency: rdata_valid[i] is high exactly READ_LATENCY cycles after the accepted cycle.
- Back-to-back reads stream at one per cycle within a burst.
- Owner change always costs exactly one dead cycle (TURN).
- Simultaneous requests from IDLE: round-robin from owner+1. After reset the scan order is 1, 2, 3, 0.
- Reset mid-burst: grant drops immediately (asynchronous). In-flight read tags are discarded, so no rdata_valid pulses after reset.
- A requester dropping req is released at that edge, with no access that cycle.

## Configuration
- SRAM_ARB_VGA_PREEMPT_EN defined:
  - A high req[0] while another requester owns forces release at the next edge, regardless of the burst counter.
  - After TURN, requester 0 wins unconditionally.
- Not defined: requester 0 is an ordinary round-robin participant.

## Test plan
- Single requester: req[2]=1, we_n[2]=1, addr=0x00010 from IDLE -> gnt[2] high next cycle. SRAM_address=0x00010 that cycle; rdata_valid[2] pulses 2 cycles later with rdata equal to the SRAM model word.
- Burst limit: req[1] and req[2] held with MAX_BURST=16 -> requester 1 gets 16 accesses, then one TURN cycle (SRAM_we_n=1, gnt=0), then gnt[2]; the pattern alternates.
- Write path: req[3]=1, we_n[3]=0, addr=0x3FFFF, wdata=0xBEEF -> SRAM_we_n=0, SRAM_address=0x3FFFF, SRAM_write_data=0xBEEF; no rdata_valid pulse.
- Preemption, macro on: requester 2 mid-burst at count 3 and req[0] rises -> gnt[2] drops next edge, TURN, then gnt[0]. Macro off: requester 2 continues to 16 accesses.
- Reset mid-read: assert Reset one cycle after three reads are accepted -> gnt=0 and SRAM_we_n=1 immediately; no rdata_valid pulses afterwards; first post-reset grant scan starts at requester 1.
